fmrv32im_axi_sram: RTL

FMRV32IM_AXI_SRAM -- requirements
Module: fmrv32im_axi_sram

---
 rtl/fmrv32im_axi_pkg.sv | 22 ++
 rtl/fmrv32im_axi_sram_mem.sv | 31 +++
 rtl/fmrv32im_axi_sram.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fmrv32im_axi_pkg.sv
// Shared AXI codes and FSM state types for the fmrv32im AXI SRAM slave.
package fmrv32im_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/fmrv32im_axi_sram_mem.sv
// Dual-port byte-enable RAM: one write port, one registered read port.
// A read and write to the same word in one cycle returns the old contents.
module fmrv32im_axi_sram_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fmrv32im_axi_sram.sv
// AXI4 SRAM slave with independent write and read burst engines.
//
// state  | meaning
// W_IDLE | waiting for write address (AWREADY)
// W_DATA | accepting write beats (WREADY)
// W_RESP | presenting write response (BVALID)
// R_IDLE | waiting for read address (ARREADY)
// R_DATA | presenting read beats (RVALID)
import fmrv32im_axi_pkg::*;

module fmrv32im_axi_sram #(
    parameter int MEM_WORDS = 1024,
    parameter int ID_W      = 1
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic [ID_W-1:0] AWID,
    input  logic [31:0]     AWADDR,
    input  logic [7:0]      AWLEN,
    input  logic [1:0]      AWBURST,
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [31:0]     WDATA,
    input  logic [3:0]      WSTRB,
    input  logic            WLAST,
    input  logic            WVALID,
    output logic            WREADY,
    output logic [ID_W-1:0] BID,
    output logic [1:0]      BRESP,
    output logic            BVALID,
    input  logic            BREADY,
    input  logic [ID_W-1:0] ARID,
    input  logic [31:0]     ARADDR,
    input  logic [7:0]      ARLEN,
    input  logic [1:0]      ARBURST,
    input  logic            ARVALID,
    output logic            ARREADY,
    output logic [ID_W-1:0] RID,
    output logic [31:0]     RDATA,
    output logic [1:0]      RRESP,
    output logic            RLAST,
    output logic            RVALID,
    input  logic            RREADY
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;

    // Holds both address channels closed until the first edge after reset release.
    logic rst_done;

    w_state_t        w_state, w_state_nxt;
    logic [ID_W-1:0] w_id;
    logic [31:0]     w_addr;
    logic [7:0]      w_len;
    logic [1:0]      w_burst;
    logic [8:0]      w_cnt;
    logic            w_err;
    logic            w_oor, w_keep, w_beat_err, mem_we;

    r_state_t        r_state, r_state_nxt;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_addr, r_nxt_addr, rd_addr;
    logic [7:0]      r_len, r_cnt;
    logic [1:0]      r_burst;
    logic            r_oor, r_last, rd_en;
    logic [31:0]     mem_rdata;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rst_done <= 1'b0;
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
        end else begin
            rst_done <= 1'b1;
            w_state  <= w_state_nxt;
            r_state  <= r_state_nxt;
        end
    end

    // Beats past AWLEN or outside the array are dropped but still consumed.
    assign w_oor      = (w_addr >= MEM_BYTES);
    assign w_keep     = !w_oor && (w_cnt <= {1'b0, w_len});
    assign w_beat_err = w_oor || (WLAST && (w_cnt != {1'b0, w_len}));

    always_comb begin
        w_state_nxt = w_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        BVALID      = 1'b0;
        mem_we      = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                AWREADY = rst_done;
                if (AWVALID && rst_done) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    mem_we = w_keep;
                    if (WLAST) w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (AWVALID && AWREADY) begin
            w_id    <= AWID;
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_burst <= AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_state == W_DATA && WVALID) begin
            w_err  <= w_err | w_beat_err;
            w_addr <= (w_burst == BURST_FIXED) ? w_addr : w_addr + 32'd4;
            if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
        end
    end

    assign BID   = w_id;
    assign BRESP = (w_state == W_RESP && w_err) ? RESP_SLVERR : RESP_OKAY;

    assign r_nxt_addr = (r_burst == BURST_FIXED) ? r_addr : r_addr + 32'd4;
    assign r_last     = (r_cnt == r_len);

    // The RAM output only advances on an accepted beat, so stalled data stays put.
    always_comb begin
        r_state_nxt = r_state;
        ARREADY     = 1'b0;
        RVALID      = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = r_nxt_addr;
        unique case (r_state)
            R_IDLE: begin
                ARREADY = rst_done;
                if (ARVALID && rst_done) begin
                    rd_en       = 1'b1;
                    rd_addr     = ARADDR;
                    r_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    if (r_last) r_state_nxt = R_IDLE;
                    else        rd_en       = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_oor   <= 1'b0;
        end else if (ARVALID && ARREADY) begin
            r_id    <= ARID;
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_burst <= ARBURST;
            r_cnt   <= '0;
            r_oor   <= (ARADDR >= MEM_BYTES);
        end else if (r_state == R_DATA && RREADY && !r_last) begin
            r_addr <= r_nxt_addr;
            r_cnt  <= r_cnt + 8'd1;
            r_oor  <= (r_nxt_addr >= MEM_BYTES);
        end
    end

    assign RID   = r_id;
    assign RLAST = RVALID && r_last;
    assign RRESP = (RVALID && r_oor) ? RESP_SLVERR : RESP_OKAY;
    assign RDATA = (RVALID && !r_oor) ? mem_rdata : 32'd0;

    fmrv32im_axi_sram_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem (
        .clk   (ACLK),
        .we    (mem_we),
        .waddr (w_addr[AW+1:2]),
        .wstrb (WSTRB),
        .wdata (WDATA),
        .re    (rd_en),
        .raddr (rd_addr[AW+1:2]),
        .rdata (mem_rdata)
    );

endmodule
